aes_spi_rx_buffer: RTL and testbench
====================================

# aes_spi_rx_buffer

Receive end of the inter-device ciphertext link. Captures the byte-wide SPI-style frame that a peer `aes_soc_device` drives out of its SPI master (`spi_tx_data` / `spi_tx_clk` / `spi_tx_cs_n`) and assembles the 16 bytes into a 128-bit block. It presents the block to the local PicoRV32 through `rx_data_ready`, `rx_irq` and a 32-bit word-read port. All link inputs are asynchronous to `clk` and are synchronized inside the block.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on the link inputs; minimum 2.
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `spi_rx_clk_in`  in  1  link clock from peer; data is sampled on its rising edge.
- `spi_rx_data_in`  in  8  link data byte from peer.
- `spi_rx_cs_n_in`  in  1  link frame select, active low.
- `rx_word_sel`  in  2  selects the word returned on `rx_word`; 0 selects bits [31:0], 3 selects bits [127:96].
- `rx_ack`  in  1  one-cycle pulse from the CPU; clears `rx_data_ready`, `rx_overrun` and `rx_frame_err`.
- `rx_word`  out  32  combinational `rx_data_buffer[32*rx_word_sel +: 32]`.
- `rx_data_buffer`  out  128  last good frame, little-endian by byte.
- `rx_data_ready`  out  1  a good frame is held and has not been acknowledged.
- `rx_irq`  out  1  level interrupt, equal to `rx_data_ready`.
- `rx_overrun`  out  1  sticky; a good frame was dropped because `rx_data_ready` was set.
- `rx_frame_err`  out  1  sticky; a frame ended with a byte count other than 16.
- `rx_busy`  out  1  the FSM is in RECV.
- `rx_byte_count`  out  5  bytes received in the current or most recent frame; saturates at 31.

## Operation
- The three link inputs each pass through a chain of `SYNC_STAGES` flops, plus one extra stage on clk and cs_n that is used for edge detection.
  - Data is always taken from the same stage as the synchronized clock, so it is aligned with the clock edge.
- FSM states: IDLE and RECV.
  - IDLE to RECV: the synchronized cs_n shows a falling edge. The block clears the shadow register and sets the byte counter to 0.
  - RECV: on each synchronized rising edge of the link clock while synchronized cs_n is low, the block writes `shadow[8*cnt +: 8]` with the data byte when cnt < 16, then increments cnt (saturating at 31). Byte 0 lands in bits [7:0].
  - RECV to IDLE: the synchronized cs_n shows a rising edge. On that cycle the frame is evaluated:
    - cnt == 16 and (`rx_data_ready` == 0 or `rx_ack` is high): copy shadow to `rx_data_buffer` and set `rx_data_ready`.
    - cnt == 16 and `rx_data_ready` == 1 and no `rx_ack`: drop the frame, set `rx_overrun`, leave the buffer unchanged.
    - cnt != 16: drop the frame and set `rx_frame_err`. This covers both short frames and frames of more than 16 bytes.
- `rx_data_buffer` changes only on a good completion. It stays stable while a later frame is being received.
- `rx_ack` in IDLE with no completion: clears `rx_data_ready`, `rx_overrun` and `rx_frame_err`. The buffer keeps its contents.
- `rx_ack` on the same cycle as a completion: the completion's updates win. `rx_data_ready` ends at 1 if the frame is good; an error flag raised by that frame stays set.
- Link clock edges while synchronized cs_n is high are ignored.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and all synchronizer flops are 1 for cs_n and 0 otherwise.
  - Reset is asynchronous and may be asserted mid-frame; the partial frame is discarded.
- Latency from a pin edge to its effect is `SYNC_STAGES`+1 rising edges of `clk`. With the default (3):
  - a byte is written 3 edges after the link clock rises;
  - `rx_data_ready` / `rx_irq` rise 3 edges after cs_n rises.
- The transmitter must meet these constraints, measured at the pins:
  - link clock high and low phases each ≥ `SYNC_STAGES`+1 `clk` periods;
  - data stable from 1 `clk` period before to `SYNC_STAGES`+1 periods after the link clock rising edge;
  - cs_n high between frames ≥ `SYNC_STAGES`+1 periods.
- `rx_ack` takes effect on the next edge; `rx_data_ready` is low on the following cycle.
- `rx_word` is combinational: zero cycles from `rx_word_sel`.

## Test plan
- Good frame: send 16 bytes 0x5a, 0xc5, 0xb4, 0x70, …, 0x69 (ciphertext 128'h69c4e0d86a7b0430d8cdb78070b4c55a, LSB byte first), with link clock at 4 `clk` periods per phase.
  - Expect: `rx_data_buffer` equals the ciphertext; `rx_data_ready` and `rx_irq` are 1 three edges after cs_n rises.
  - Expect: `rx_word` with sel=3 gives 0x69c4e0d8 and sel=0 gives 0x70b4c55a.
  - Expect: `rx_byte_count` = 16.
- Short frame: send 10 bytes. Expect `rx_frame_err`=1, `rx_data_ready`=0, buffer unchanged. Then send 17 bytes. Expect `rx_frame_err`=1 and `rx_byte_count`=17.
- Overrun: send a good frame A, then a good frame B without acking. Expect `rx_overrun`=1 and the buffer still holding A.
  - Then pulse `rx_ack`. Expect all flags 0 and the buffer still holding A.
- Ack collision: hold `rx_ack` high on the exact completion cycle of frame B while A is pending. Expect the buffer to hold B, `rx_data_ready`=1 and `rx_overrun`=0.
- Reset mid-frame: assert `resetn`=0 after byte 7, then release it. Expect all outputs 0.
  - Then send a full frame and expect clean reception with no `rx_frame_err`.
- Noise: toggle the link clock with cs_n high. Expect `rx_byte_count` unchanged and no flags raised.

Source files
------------

// File: rtl/aes_spi_rx_buffer.sv
// Receive side of the inter-device ciphertext link: synchronizes the peer's byte-wide
// SPI-style frame and assembles 16 bytes into a 128-bit block for the local CPU.
module aes_spi_rx_buffer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         spi_rx_clk_in,
    input  logic [7:0]   spi_rx_data_in,
    input  logic         spi_rx_cs_n_in,
    input  logic [1:0]   rx_word_sel,
    input  logic         rx_ack,
    output logic [31:0]  rx_word,
    output logic [127:0] rx_data_buffer,
    output logic         rx_data_ready,
    output logic         rx_irq,
    output logic         rx_overrun,
    output logic         rx_frame_err,
    output logic         rx_busy,
    output logic [4:0]   rx_byte_count
);
    localparam int unsigned BLOCK_BITS  = 128;
    localparam int unsigned FRAME_BYTES = 16;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned CNT_MAX     = 31;

    typedef enum logic [0:0] {IDLE, RECV} state_t;

    state_t                          state_q, state_d;
    logic [SYNC_STAGES:0]            sclk_q;
    logic [SYNC_STAGES:0]            cs_q;
    logic [SYNC_STAGES-1:0][7:0]     data_q;
    logic [BLOCK_BITS-1:0]           shadow_q, shadow_d;
    logic [BLOCK_BITS-1:0]           buf_q, buf_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            ready_q, ready_d;
    logic                            ovr_q, ovr_d;
    logic                            err_q, err_d;

    logic       sclk_rise;
    logic       cs_fall;
    logic       cs_rise;
    logic       cs_low;
    logic [7:0] sync_byte;

    // Link synchronizers; the last clk/cs stage exists only for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_q <= '0;
            cs_q   <= '1;
            data_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-1:0], spi_rx_clk_in};
            cs_q   <= {cs_q[SYNC_STAGES-1:0], spi_rx_cs_n_in};
            data_q <= {data_q[SYNC_STAGES-2:0], spi_rx_data_in};
        end
    end

    // Data is read from the same stage as the synchronized clock so the byte matches its edge.
    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
    assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
    assign cs_low    = ~cs_q[SYNC_STAGES-1];
    assign sync_byte = data_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            buf_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            ovr_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            ovr_q    <= ovr_d;
            err_q    <= err_d;
        end
    end

    // Ack clears first so that a completion on the same cycle overrides it.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        ovr_d    = ovr_q;
        err_d    = err_q;

        if (rx_ack) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
            err_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d  = RECV;
                    shadow_d = '0;
                    cnt_d    = '0;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_W'(FRAME_BYTES)) begin
                        if (!ready_q || rx_ack) begin
                            buf_d   = shadow_q;
                            ready_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sclk_rise && cs_low) begin
                    if (cnt_q < CNT_W'(FRAME_BYTES)) begin
                        shadow_d[{cnt_q[3:0], 3'b000} +: 8] = sync_byte;
                    end
                    if (cnt_q != CNT_W'(CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data_buffer = buf_q;
    assign rx_data_ready  = ready_q;
    assign rx_irq         = ready_q;
    assign rx_overrun     = ovr_q;
    assign rx_frame_err   = err_q;
    assign rx_busy        = (state_q == RECV);
    assign rx_byte_count  = cnt_q;
    assign rx_word        = buf_q[{rx_word_sel, 5'b00000} +: 32];

endmodule

// File: tb/tb_aes_spi_rx_buffer.sv
// Self-checking bench for aes_spi_rx_buffer: directed and random frames against a
// frame-level reference model of the receive buffer and its flags.
module tb_aes_spi_rx_buffer;
    logic         clk = 1'b0;
    logic         resetn;
    logic         spi_clk;
    logic [7:0]   spi_data;
    logic         spi_cs_n;
    logic [1:0]   rx_word_sel;
    logic         rx_ack;
    logic [31:0]  rx_word;
    logic [127:0] rx_data_buffer;
    logic         rx_data_ready;
    logic         rx_irq;
    logic         rx_overrun;
    logic         rx_frame_err;
    logic         rx_busy;
    logic [4:0]   rx_byte_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [127:0] eb;
    logic         er, eo, ee;
    int           ecnt;
    logic [7:0]   fb [0:39];

    aes_spi_rx_buffer #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .spi_rx_clk_in  (spi_clk),
        .spi_rx_data_in (spi_data),
        .spi_rx_cs_n_in (spi_cs_n),
        .rx_word_sel    (rx_word_sel),
        .rx_ack         (rx_ack),
        .rx_word        (rx_word),
        .rx_data_buffer (rx_data_buffer),
        .rx_data_ready  (rx_data_ready),
        .rx_irq         (rx_irq),
        .rx_overrun     (rx_overrun),
        .rx_frame_err   (rx_frame_err),
        .rx_busy        (rx_busy),
        .rx_byte_count  (rx_byte_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sel;
        chk({tag, ".buffer"}, rx_data_buffer, eb);
        chk({tag, ".ready"}, 128'(rx_data_ready), 128'(er));
        chk({tag, ".irq"}, 128'(rx_irq), 128'(er));
        chk({tag, ".overrun"}, 128'(rx_overrun), 128'(eo));
        chk({tag, ".frame_err"}, 128'(rx_frame_err), 128'(ee));
        chk({tag, ".busy"}, 128'(rx_busy), 128'(0));
        chk({tag, ".count"}, 128'(rx_byte_count), 128'(ecnt));
        sel = int'($urandom_range(0, 3));
        rx_word_sel = 2'(sel);
        #1;
        chk({tag, ".word"}, 128'(rx_word), 128'(eb[32*sel +: 32]));
    endtask

    // Frame-level rules: ack clears flags, then the frame's outcome is applied.
    task automatic model_end(input int n, input bit ack);
        if (ack) begin
            er = 1'b0;
            eo = 1'b0;
            ee = 1'b0;
        end
        ecnt = (n > 31) ? 31 : n;
        if (n == 16) begin
            if (!er) begin
                for (int i = 0; i < 16; i++) eb[8*i +: 8] = fb[i];
                er = 1'b1;
            end else begin
                eo = 1'b1;
            end
        end else begin
            ee = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        spi_data = b;
        tick();
        spi_clk = 1'b1;
        repeat (4) tick();
        spi_clk = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_frame(input int n, input bit ack);
        logic was_ready;
        spi_cs_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < n; i++) begin
            send_byte(fb[i]);
            if (i == 2) chk("busy_mid_frame", 128'(rx_busy), 128'(1));
        end
        was_ready = er;
        spi_cs_n = 1'b1;
        tick();
        tick();
        if (!was_ready) chk("ready_not_early", 128'(rx_data_ready), 128'(0));
        if (ack) rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        model_end(n, ack);
        chk("ready_at_latency", 128'(rx_data_ready), 128'(er));
        repeat (4) tick();
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        er = 1'b0;
        eo = 1'b0;
        ee = 1'b0;
        chk("ack_ready_low", 128'(rx_data_ready), 128'(0));
    endtask

    initial begin
        logic [127:0] ct;
        int n;
        resetn      = 1'b0;
        spi_clk     = 1'b0;
        spi_data    = 8'h00;
        spi_cs_n    = 1'b1;
        rx_word_sel = 2'd0;
        rx_ack      = 1'b0;
        eb = '0; er = 1'b0; eo = 1'b0; ee = 1'b0; ecnt = 0;
        repeat (3) tick();
        check_all("reset");
        resetn = 1'b1;
        repeat (3) tick();

        // Directed ciphertext frame
        ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        for (int i = 0; i < 16; i++) fb[i] = ct[8*i +: 8];
        send_frame(16, 1'b0);
        check_all("good");
        chk("good.ct", rx_data_buffer, ct);
        rx_word_sel = 2'd3;
        #1 chk("word_sel3", 128'(rx_word), 128'(32'h69c4e0d8));
        rx_word_sel = 2'd0;
        #1 chk("word_sel0", 128'(rx_word), 128'(32'h70b4c55a));

        // Short then long frames
        pulse_ack();
        fill_random(10);
        send_frame(10, 1'b0);
        check_all("short10");
        fill_random(17);
        send_frame(17, 1'b0);
        check_all("long17");
        pulse_ack();
        check_all("ack_after_err");

        // Overrun
        fill_random(16);
        send_frame(16, 1'b0);
        fill_random(16);
        send_frame(16, 1'b0);
        check_all("overrun");
        pulse_ack();
        check_all("overrun_acked");

        // Ack on the completion cycle while A is pending
        fill_random(16);
        send_frame(16, 1'b0);
        fill_random(16);
        send_frame(16, 1'b1);
        check_all("ack_collision");
        pulse_ack();

        // Reset mid-frame
        fill_random(16);
        spi_cs_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 7; i++) send_byte(fb[i]);
        resetn = 1'b0;
        #1;
        eb = '0; er = 1'b0; eo = 1'b0; ee = 1'b0; ecnt = 0;
        check_all("reset_mid_frame");
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        repeat (4) tick();
        check_all("after_reset");
        fill_random(16);
        send_frame(16, 1'b0);
        check_all("post_reset_frame");

        // Link clock noise with cs_n high
        for (int i = 0; i < 6; i++) begin
            spi_data = 8'($urandom);
            spi_clk  = 1'b1;
            repeat (4) tick();
            spi_clk  = 1'b0;
            repeat (4) tick();
        end
        check_all("noise");

        // Saturating count
        fill_random(35);
        send_frame(35, 1'b0);
        check_all("saturate");

        // Random frames
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 2) == 0) pulse_ack();
            n = ($urandom_range(0, 2) != 0) ? 16 : int'($urandom_range(1, 20));
            fill_random(n);
            send_frame(n, 1'($urandom_range(0, 3) == 0));
            check_all("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
